// File: rtl/spram_bank_power_ctrl_pkg.sv
// Shared encodings for the SPRAM bank power sequencer: per-bank state codes and
// the STANDBY/SLEEP/POWEROFF pin pattern that each state drives.
package spram_bank_power_ctrl_pkg;

   localparam logic [2:0] ST_ACTIVE  = 3'd0;
   localparam logic [2:0] ST_STANDBY = 3'd1;
   localparam logic [2:0] ST_SLEEP   = 3'd2;
   localparam logic [2:0] ST_WAKE    = 3'd3;
   localparam logic [2:0] ST_OFF     = 3'd4;

   // POWEROFF is active-low on the macro: 1 keeps the bank powered.
   typedef struct packed {
      logic standby;
      logic sleep;
      logic poweroff;
   } pin_pat_t;

   localparam pin_pat_t PINS_ACTIVE  = '{standby: 1'b0, sleep: 1'b0, poweroff: 1'b1};
   localparam pin_pat_t PINS_STANDBY = '{standby: 1'b1, sleep: 1'b0, poweroff: 1'b1};
   localparam pin_pat_t PINS_SLEEP   = '{standby: 1'b0, sleep: 1'b1, poweroff: 1'b1};
   localparam pin_pat_t PINS_WAKE    = '{standby: 1'b0, sleep: 1'b0, poweroff: 1'b1};
   localparam pin_pat_t PINS_OFF     = '{standby: 1'b0, sleep: 1'b0, poweroff: 1'b0};

   function automatic pin_pat_t pins_for_state(input logic [2:0] st);
      pin_pat_t p;
      case (st)
         ST_STANDBY: p = PINS_STANDBY;
         ST_SLEEP:   p = PINS_SLEEP;
         ST_WAKE:    p = PINS_WAKE;
         ST_OFF:     p = PINS_OFF;
         default:    p = PINS_ACTIVE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/spram_bank_power_ctrl_fsm.sv
// Per-bank power FSM: tracks idle time, steps the bank through standby/sleep,
// runs the wake-up delay and drives the registered SPRAM power pins.
module spram_bank_pwr_fsm
   import spram_bank_power_ctrl_pkg::*;
#(
   parameter int IDLE_STANDBY = 16,
   parameter int IDLE_SLEEP   = 256,
   parameter int WAKE_CYCLES  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic force_off_i,
   input  logic req_i,
   input  logic grant_i,
   output logic is_active_o,
   output logic is_off_o,
   output logic standby_o,
   output logic sleep_o,
   output logic poweroff_o
);

   localparam int IDLE_W = $clog2(IDLE_SLEEP + 1);
   localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

   localparam logic [IDLE_W-1:0] IDLE_STBY_LAST = IDLE_W'(IDLE_STANDBY - 1);
   localparam logic [IDLE_W-1:0] IDLE_SLP_LAST  = IDLE_W'(IDLE_SLEEP - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX       = IDLE_W'(IDLE_SLEEP);
   localparam logic [WAKE_W-1:0] WAKE_LAST      = WAKE_W'(WAKE_CYCLES - 1);

   logic [2:0]        state_q, state_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [WAKE_W-1:0] wake_q, wake_d;
   pin_pat_t          pins_q, pins_d;
   logic              enter_active;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_d = state_q;
      if (force_off_i) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF:     state_d = ST_WAKE;
            ST_ACTIVE:  if (!grant_i && idle_q == IDLE_STBY_LAST) state_d = ST_STANDBY;
            ST_STANDBY: begin
               if (req_i)                        state_d = ST_ACTIVE;
               else if (idle_q == IDLE_SLP_LAST) state_d = ST_SLEEP;
            end
            ST_SLEEP:   if (req_i) state_d = ST_WAKE;
            ST_WAKE:    if (wake_q == WAKE_LAST) state_d = ST_ACTIVE;
            default:    state_d = ST_ACTIVE;
         endcase
      end
   end

   assign enter_active = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);

   always_comb begin
      idle_d = idle_q;
      if (grant_i || enter_active) idle_d = '0;
      else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
   end

   // The wake counter only runs while the bank stays in WAKE; any other path restarts it.
   assign wake_d = (state_q == ST_WAKE && state_d == ST_WAKE) ? wake_q + 1'b1 : '0;

   assign pins_d = pins_for_state(state_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACTIVE;
         idle_q  <= '0;
         wake_q  <= '0;
         pins_q  <= PINS_ACTIVE;
      end else begin
         // NOTE: non-blocking so all flops sample the pre-edge values together.
         state_q <= state_d;
         idle_q  <= idle_d;
         wake_q  <= wake_d;
         pins_q  <= pins_d;
      end
   end

   assign is_active_o = (state_q == ST_ACTIVE);
   assign is_off_o    = (state_q == ST_OFF);
   assign standby_o   = pins_q.standby;
   assign sleep_o     = pins_q.sleep;
   assign poweroff_o  = pins_q.poweroff;

endmodule

// File: rtl/spram_bank_power_ctrl.sv
// Power/access sequencer for the banked SPRAM: decodes the target bank, gates the
// memory handshake on bank readiness and hosts one power FSM per bank.
module spram_bank_power_ctrl
   import spram_bank_power_ctrl_pkg::*;
#(
   parameter int NUM_BANKS    = 2,
   parameter int ADDR_W       = 15,
   parameter int IDLE_STANDBY = 16,
   parameter int IDLE_SLEEP   = 256,
   parameter int WAKE_CYCLES  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic                 req_wren,
   output logic                 req_ready,
   output logic                 req_err,
   input  logic [NUM_BANKS-1:0] force_off,
   output logic                 mem_chip_sel,
   output logic                 mem_wren,
   output logic [NUM_BANKS-1:0] standby,
   output logic [NUM_BANKS-1:0] sleep,
   output logic [NUM_BANKS-1:0] poweroff
);

   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [BANK_W-1:0]    bank_sel;
   logic                 addr_unused;
   logic [NUM_BANKS-1:0] bank_active;
   logic [NUM_BANKS-1:0] bank_off;
   logic [NUM_BANKS-1:0] bank_req;
   logic [NUM_BANKS-1:0] bank_grant;
   logic                 tgt_active;
   logic                 tgt_off;
   logic                 tgt_forced;

   // Only the top address bits pick the bank; the rest belong to the memory itself.
   if (NUM_BANKS > 1) begin : g_multi
      assign bank_sel    = req_addr[ADDR_W-1 -: BANK_W];
      assign addr_unused = ^req_addr[ADDR_W-BANK_W-1:0];
   end else begin : g_single
      assign bank_sel    = '0;
      assign addr_unused = ^req_addr;
   end

   assign tgt_active = bank_active[bank_sel];
   assign tgt_off    = bank_off[bank_sel];
   assign tgt_forced = force_off[bank_sel];

   // Reset masks the handshake so a request held across reset is re-evaluated afterwards.
   assign req_ready    = rst_n & req_valid & tgt_active & ~tgt_forced;
   assign req_err      = rst_n & req_valid & (tgt_off | tgt_forced);
   assign mem_chip_sel = req_valid & req_ready;
   assign mem_wren     = req_wren & req_valid & req_ready;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign bank_req[b]   = req_valid & (bank_sel == BANK_W'(b));
      assign bank_grant[b] = req_ready & (bank_sel == BANK_W'(b));

      spram_bank_pwr_fsm #(
         .IDLE_STANDBY (IDLE_STANDBY),
         .IDLE_SLEEP   (IDLE_SLEEP),
         .WAKE_CYCLES  (WAKE_CYCLES)
      ) u_fsm (
         .clk         (clk),
         .rst_n       (rst_n),
         .force_off_i (force_off[b]),
         .req_i       (bank_req[b]),
         .grant_i     (bank_grant[b]),
         .is_active_o (bank_active[b]),
         .is_off_o    (bank_off[b]),
         .standby_o   (standby[b]),
         .sleep_o     (sleep[b]),
         .poweroff_o  (poweroff[b])
      );
   end

endmodule

// File: tb/tb_spram_bank_power_ctrl.sv
// Bench for spram_bank_power_ctrl: directed scenarios then random traffic, each cycle
// compared against a per-bank mode/countdown model of the power policy.
module tb_spram_bank_power_ctrl;

   localparam int NB           = 2;
   localparam int ADDR_W       = 15;
   localparam int BW           = 1;
   localparam int IDLE_STANDBY = 16;
   localparam int IDLE_SLEEP   = 256;
   localparam int WAKE_CYCLES  = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic              req_wren = 1'b0;
   logic [NB-1:0]     force_off = '0;
   logic              req_ready, req_err, mem_chip_sel, mem_wren;
   logic [NB-1:0]     standby, sleep, poweroff;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   spram_bank_power_ctrl #(
      .NUM_BANKS    (NB),
      .ADDR_W       (ADDR_W),
      .IDLE_STANDBY (IDLE_STANDBY),
      .IDLE_SLEEP   (IDLE_SLEEP),
      .WAKE_CYCLES  (WAKE_CYCLES)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_wren     (req_wren),
      .req_ready    (req_ready),
      .req_err      (req_err),
      .force_off    (force_off),
      .mem_chip_sel (mem_chip_sel),
      .mem_wren     (mem_wren),
      .standby      (standby),
      .sleep        (sleep),
      .poweroff     (poweroff)
   );

   // Reference model: each bank is in a mode, with elapsed quiet time and a wake countdown.
   typedef enum {B_RUN, B_DOZE, B_NAP, B_WARM, B_DEAD} bmode_e;
   bmode_e m_mode [NB];
   int     m_quiet[NB];
   int     m_warm [NB];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int tgt_of(input logic [ADDR_W-1:0] a);
      return int'(a[ADDR_W-1 -: BW]);
   endfunction

   function automatic bit exp_ready();
      int t = tgt_of(req_addr);
      return rst_n && req_valid && (m_mode[t] == B_RUN) && !force_off[t];
   endfunction

   function automatic bit exp_err();
      int t = tgt_of(req_addr);
      return rst_n && req_valid && ((m_mode[t] == B_DEAD) || force_off[t]);
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         m_mode[b]  = B_RUN;
         m_quiet[b] = 0;
         m_warm[b]  = 0;
      end
   endtask

   task automatic model_edge();
      bit rdy = exp_ready();
      int t   = tgt_of(req_addr);
      for (int b = 0; b < NB; b++) begin
         bit     asked   = req_valid && (t == b);
         bit     granted = rdy && (t == b);
         bmode_e nxt     = m_mode[b];
         if (force_off[b]) nxt = B_DEAD;
         else begin
            case (m_mode[b])
               B_DEAD: begin nxt = B_WARM; m_warm[b] = WAKE_CYCLES; end
               B_RUN:  if (!granted && m_quiet[b] + 1 >= IDLE_STANDBY) nxt = B_DOZE;
               B_DOZE: begin
                  if (asked) nxt = B_RUN;
                  else if (m_quiet[b] + 1 >= IDLE_SLEEP) nxt = B_NAP;
               end
               B_NAP:  if (asked) begin nxt = B_WARM; m_warm[b] = WAKE_CYCLES; end
               B_WARM: if (m_warm[b] == 1) nxt = B_RUN; else m_warm[b] = m_warm[b] - 1;
               default: nxt = m_mode[b];
            endcase
         end
         if (granted || (nxt == B_RUN && m_mode[b] != B_RUN)) m_quiet[b] = 0;
         else if (m_quiet[b] < IDLE_SLEEP) m_quiet[b] = m_quiet[b] + 1;
         m_mode[b] = nxt;
      end
   endtask

   task automatic compare_all();
      logic [NB-1:0] e_sb, e_sl, e_po;
      bit er, ee;
      e_sb = '0; e_sl = '0; e_po = '0;
      for (int b = 0; b < NB; b++) begin
         e_sb[b] = (m_mode[b] == B_DOZE);
         e_sl[b] = (m_mode[b] == B_NAP);
         e_po[b] = (m_mode[b] != B_DEAD);
      end
      er = exp_ready();
      ee = exp_err();
      check("cyc_ready",    req_ready,    er);
      check("cyc_err",      req_err,      ee);
      check("cyc_chip_sel", mem_chip_sel, er);
      check("cyc_wren",     mem_wren,     er && req_wren);
      check("cyc_standby",  standby,      e_sb);
      check("cyc_sleep",    sleep,        e_sl);
      check("cyc_poweroff", poweroff,     e_po);
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_ready(input int max_cycles, output int n);
      n = 0;
      while (req_ready !== 1'b1 && n < max_cycles) begin
         step();
         #1;
         n++;
      end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bit pending;
      int fb;

      // Reset with a request already pending; granted the moment reset lifts.
      model_reset();
      req_valid = 1'b1;
      req_addr  = 15'h0004;
      #12;
      check("rst_ready",    req_ready, 0);
      check("rst_err",      req_err,   0);
      check("rst_standby",  standby,   2'b00);
      check("rst_sleep",    sleep,     2'b00);
      check("rst_poweroff", poweroff,  2'b11);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("t1_ready",    req_ready,    1);
      check("t1_chip_sel", mem_chip_sel, 1);
      check("t1_poweroff", poweroff,     2'b11);
      step();
      req_valid = 1'b0;

      // Idle timeouts: standby after 16 quiet cycles, sleep after 256.
      do_reset();
      repeat (15) step();
      #1; check("t2_standby_15", standby, 2'b00);
      step();
      #1; check("t2_standby_16", standby, 2'b11);
      repeat (239) step();
      #1; check("t2_sleep_255", sleep, 2'b00);
      step();
      #1; check("t2_sleep_256", sleep, 2'b11);
      check("t2_standby_256", standby, 2'b00);

      // Wake bank 1 from sleep: ready four cycles after valid, bank 0 untouched.
      req_valid = 1'b1;
      req_addr  = 15'h4000;
      #1; check("t3_ready_0", req_ready, 0);
      step();
      #1; check("t3_sleep_1", sleep, 2'b01);
      wait_ready(20, n);
      check("t3_latency", n + 1, 4);
      step();
      req_valid = 1'b0;

      // Write to a bank in standby: one-cycle latency, single write strobe.
      do_reset();
      repeat (16) step();
      #1; check("t4_standby", standby, 2'b11);
      req_valid = 1'b1;
      req_addr  = 15'h0010;
      req_wren  = 1'b1;
      #1;
      check("t4_ready_0", req_ready, 0);
      check("t4_wren_0",  mem_wren,  0);
      step();
      #1;
      check("t4_ready_1", req_ready, 1);
      check("t4_wren_1",  mem_wren,  1);
      step();
      req_valid = 1'b0;
      req_wren  = 1'b0;
      #1;
      check("t4_wren_2",    mem_wren, 0);
      check("t4_standby_2", standby,  2'b10);

      // Force bank 1 off, release into WAKE, then abort that WAKE with a request pending.
      force_off = 2'b10;
      step();
      #1; check("t5_off", poweroff, 2'b01);
      force_off = 2'b00;
      step();
      #1; check("t5_wake_pwr", poweroff, 2'b11);
      step();
      force_off = 2'b10;
      req_valid = 1'b1;
      req_addr  = 15'h4000;
      #1;
      check("t5_err_force",   req_err,   1);
      check("t5_ready_force", req_ready, 0);
      step();
      #1;
      check("t5_abort_pwr", poweroff,  2'b01);
      check("t5_err_off",   req_err,   1);
      repeat (2) step();
      #1; check("t5_cs_off", mem_chip_sel, 0);
      force_off = 2'b00;
      #1; check("t5_err_release", req_err, 1);
      step();
      #1;
      check("t5_err_wake",   req_err,   0);
      check("t5_ready_wake", req_ready, 0);
      wait_ready(20, n);
      check("t5_wake_latency", n, 3);
      step();
      req_valid = 1'b0;

      // Asynchronous reset in the middle of a bank 0 wake with a request held.
      force_off = 2'b01;
      step();
      force_off = 2'b00;
      step();
      step();
      req_valid = 1'b1;
      req_addr  = 15'h0004;
      #1; check("t6_ready_wake", req_ready, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("t6_rst_pwr",     poweroff,     2'b11);
      check("t6_rst_standby", standby,      2'b00);
      check("t6_rst_sleep",   sleep,        2'b00);
      check("t6_rst_ready",   req_ready,    0);
      check("t6_rst_cs",      mem_chip_sel, 0);
      @(posedge clk); #2;
      check("t6_rst_hold", req_ready, 0);
      rst_n = 1'b1;
      #1;
      check("t6_ready_after", req_ready,    1);
      check("t6_cs_after",    mem_chip_sel, 1);
      step();
      req_valid = 1'b0;

      // Random traffic: requester holds a stalled request, force_off toggles occasionally.
      pending = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!pending) begin
            if ($urandom_range(0, 99) == 0) begin
               req_valid = 1'b0;
               repeat ($urandom_range(0, 300)) step();
            end
            req_valid = ($urandom_range(0, 3) == 0);
            req_addr  = ADDR_W'($urandom);
            req_wren  = ($urandom_range(0, 1) == 1);
         end
         if ($urandom_range(0, 31) == 0) begin
            fb = $urandom_range(0, NB - 1);
            force_off[fb] = ~force_off[fb];
         end
         pending = req_valid && !exp_ready() && !exp_err();
         step();
      end
      force_off = '0;
      req_valid = 1'b0;
      repeat (8) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
